int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 13 +
 rtl/int_ctrl.sv | 119 +++++++++++
 tb/tb_int_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// CPU bus port of the interrupt controller: IF/IE register reads and writes.
interface int_ctrl_if;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        bus_sel;

    modport master (output bus_addr, output bus_wdata, output bus_wr,
                    input  bus_rdata, input bus_sel);
    modport slave  (input  bus_addr, input bus_wdata, input bus_wr,
                    output bus_rdata, output bus_sel);
endinterface

// File: rtl/int_ctrl.sv
// Game Boy style interrupt controller: IF/IE registers, IME with delayed EI,
// and a two-state dispatch handshake towards the CPU sequencer.
module int_ctrl (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           int_req,
    int_ctrl_if.slave            bus,
    input  logic                 ei_cmd,
    input  logic                 di_cmd,
    input  logic                 reti_cmd,
    input  logic                 instr_boundary,
    input  logic                 int_ack,
    output logic                 int_pending,
    output logic [2:0]           int_vector,
    output logic                 halt_wake,
    output logic                 ime
);
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic {IDLE, DISPATCH} state_t;

    state_t      state, state_next;
    logic [4:0]  if_reg, if_next;
    logic [7:0]  ie_reg, ie_next;
    logic        ime_next;
    logic        ei_delay, ei_delay_next;
    logic [2:0]  vector_next;
    logic        wr_if, wr_ie;
    logic        ack;
    logic [4:0]  ack_mask;
    logic [4:0]  active;

    function automatic logic [2:0] lowest_set(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign wr_if     = bus.bus_wr && (bus.bus_addr == ADDR_IF);
    assign wr_ie     = bus.bus_wr && (bus.bus_addr == ADDR_IE);
    assign active    = ie_reg[4:0] & if_reg;
    assign halt_wake = |active;
    assign ack       = (state == DISPATCH) && int_ack;
    assign ack_mask  = ack ? (5'b00001 << int_vector) : 5'b00000;

    assign bus.bus_sel   = (bus.bus_addr == ADDR_IF) || (bus.bus_addr == ADDR_IE);
    assign bus.bus_rdata = (bus.bus_addr == ADDR_IF) ? {3'b111, if_reg} :
                           (bus.bus_addr == ADDR_IE) ? ie_reg : 8'hFF;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            int_pending <= 1'b0;
        end else begin
            state       <= state_next;
            int_pending <= (state_next == DISPATCH);
        end
    end

    always_comb begin
        state_next    = state;
        vector_next   = int_vector;
        ime_next      = ime;
        ei_delay_next = ei_delay;
        // Peripheral requests are OR'd last so they survive a write or ack clear.
        if_next       = (wr_if ? bus.bus_wdata[4:0] : (if_reg & ~ack_mask)) | int_req;
        ie_next       = wr_ie ? bus.bus_wdata : ie_reg;

        case (state)
            IDLE: begin
                if (ime && instr_boundary && (active != 5'b00000)) begin
                    state_next  = DISPATCH;
                    vector_next = lowest_set(active);
                end
                if (di_cmd) begin
                    ime_next      = 1'b0;
                    ei_delay_next = 1'b0;
                end else begin
                    if (reti_cmd) ime_next = 1'b1;
                    // The boundary of the EI instruction itself must not release IME.
                    if (ei_cmd) begin
                        ei_delay_next = 1'b1;
                    end else if (ei_delay && instr_boundary) begin
                        ime_next      = 1'b1;
                        ei_delay_next = 1'b0;
                    end
                end
            end
            DISPATCH: begin
                if (int_ack) begin
                    state_next    = IDLE;
                    ime_next      = 1'b0;
                    ei_delay_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_reg     <= 5'd0;
            ie_reg     <= 8'd0;
            ime        <= 1'b0;
            ei_delay   <= 1'b0;
            int_vector <= 3'd0;
        end else begin
            if_reg     <= if_next;
            ie_reg     <= ie_next;
            ime        <= ime_next;
            ei_delay   <= ei_delay_next;
            int_vector <= vector_next;
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: dispatched vectors are queued when the
// qualifying boundary is driven and compared when int_pending rises.
module tb_int_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] int_req;
    logic       ei_cmd, di_cmd, reti_cmd, instr_boundary, int_ack;
    logic       int_pending;
    logic [2:0] int_vector;
    logic       halt_wake, ime;

    int_ctrl_if bif ();

    int_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .int_req        (int_req),
        .bus            (bif),
        .ei_cmd         (ei_cmd),
        .di_cmd         (di_cmd),
        .reti_cmd       (reti_cmd),
        .instr_boundary (instr_boundary),
        .int_ack        (int_ack),
        .int_pending    (int_pending),
        .int_vector     (int_vector),
        .halt_wake      (halt_wake),
        .ime            (ime)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] sb_vec[$];
    logic       prev_pending = 1'b0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: each new dispatch must match the oldest queued vector.
    always @(negedge clock) begin
        if (int_pending && !prev_pending) begin
            if (sb_vec.size() == 0) check_val("unexpected_dispatch", 16'(int_vector), 16'hFFFF);
            else check_val("sb_vector", 16'(int_vector), 16'(sb_vec.pop_front()));
        end
        prev_pending = int_pending;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bif.bus_addr  = a;
        bif.bus_wdata = d;
        bif.bus_wr    = 1'b1;
        tick();
        bif.bus_wr    = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [15:0] a,
                              input logic [7:0] exp, input logic exp_sel);
        bif.bus_addr = a;
        #1;
        check_val(tag, 16'(bif.bus_rdata), 16'(exp));
        check_val({tag, "_sel"}, 16'(bif.bus_sel), 16'(exp_sel));
    endtask

    task automatic raise(input logic [4:0] r);
        int_req = r;
        tick();
        int_req = 5'd0;
    endtask

    task automatic do_reti();
        reti_cmd = 1'b1;
        tick();
        reti_cmd = 1'b0;
    endtask

    task automatic boundary();
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
    endtask

    task automatic dispatch(input string tag, input logic [2:0] v);
        sb_vec.push_back(v);
        boundary();
        check_val({tag, "_pending"}, 16'(int_pending), 16'd1);
        check_val({tag, "_vector"}, 16'(int_vector), 16'(v));
    endtask

    task automatic ack_it();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; int_req = 5'd0; ei_cmd = 1'b0; di_cmd = 1'b0; reti_cmd = 1'b0;
        instr_boundary = 1'b0; int_ack = 1'b0;
        bif.bus_addr = 16'h0000; bif.bus_wdata = 8'h00; bif.bus_wr = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_val("rst_pending", 16'(int_pending), 16'd0);
        check_val("rst_ime", 16'(ime), 16'd0);
        check_val("rst_wake", 16'(halt_wake), 16'd0);
        check_val("rst_vector", 16'(int_vector), 16'd0);
        check_read("rst_if", 16'hFF0F, 8'hE0, 1'b1);
        check_read("rst_ie", 16'hFFFF, 8'h00, 1'b1);
        check_read("other_addr", 16'h1234, 8'hFF, 1'b0);

        // Basic timer dispatch
        bus_write(16'hFFFF, 8'h05);
        raise(5'h04);
        do_reti();
        check_val("reti_ime", 16'(ime), 16'd1);
        dispatch("timer", 3'd2);
        ack_it();
        check_read("timer_if_after", 16'hFF0F, 8'hE0, 1'b1);
        check_val("timer_ime_after", 16'(ime), 16'd0);
        check_val("timer_pending_after", 16'(int_pending), 16'd0);

        // Priority pick among several pending bits
        bus_write(16'hFFFF, 8'h1F);
        check_read("ie_full", 16'hFFFF, 8'h1F, 1'b1);
        bus_write(16'hFF0F, 8'h1A);
        do_reti();
        dispatch("prio", 3'd1);
        ack_it();
        check_read("prio_if_after", 16'hFF0F, 8'hF8, 1'b1);

        // Delayed EI and DI override
        bus_write(16'hFF0F, 8'h00);
        ei_cmd = 1'b1; instr_boundary = 1'b1;
        tick();
        ei_cmd = 1'b0; instr_boundary = 1'b0;
        check_val("ei_same_boundary", 16'(ime), 16'd0);
        boundary();
        check_val("ei_next_boundary", 16'(ime), 16'd1);
        di_cmd = 1'b1; tick(); di_cmd = 1'b0;
        check_val("di_clear", 16'(ime), 16'd0);
        ei_cmd = 1'b1; tick(); ei_cmd = 1'b0;
        di_cmd = 1'b1; tick(); di_cmd = 1'b0;
        boundary();
        check_val("di_cancels_ei", 16'(ime), 16'd0);
        ei_cmd = 1'b1; di_cmd = 1'b1; tick(); ei_cmd = 1'b0; di_cmd = 1'b0;
        boundary();
        check_val("di_beats_ei", 16'(ime), 16'd0);

        // Same-cycle request beats the ack clear
        bus_write(16'hFFFF, 8'h01);
        raise(5'h01);
        do_reti();
        dispatch("vblank", 3'd0);
        int_ack = 1'b1; int_req = 5'h01;
        tick();
        int_ack = 1'b0; int_req = 5'h00;
        check_read("req_beats_ack", 16'hFF0F, 8'hE1, 1'b1);
        check_val("req_beats_ack_pending", 16'(int_pending), 16'd0);
        check_val("req_beats_ack_ime", 16'(ime), 16'd0);
        bus_write(16'hFF0F, 8'h00);

        // halt_wake is independent of IME
        bus_write(16'hFFFF, 8'h10);
        raise(5'h10);
        check_val("wake_set", 16'(halt_wake), 16'd1);
        boundary();
        check_val("wake_no_dispatch", 16'(int_pending), 16'd0);
        bus_write(16'hFF0F, 8'h00);
        check_val("wake_clear", 16'(halt_wake), 16'd0);

        // Writes and commands during DISPATCH; ack in IDLE ignored; no back-to-back
        bus_write(16'hFFFF, 8'h1F);
        bus_write(16'hFF0F, 8'h14);
        do_reti();
        dispatch("hold", 3'd2);
        bus_write(16'hFF0F, 8'h01);
        check_val("hold_vector_write", 16'(int_vector), 16'd2);
        di_cmd = 1'b1; tick(); di_cmd = 1'b0;
        check_val("di_ignored_dispatch", 16'(ime), 16'd1);
        ack_it();
        check_read("hold_if_after", 16'hFF0F, 8'hE1, 1'b1);
        check_val("hold_vector_after", 16'(int_vector), 16'd2);
        ack_it();
        check_read("idle_ack_ignored", 16'hFF0F, 8'hE1, 1'b1);
        boundary();
        check_val("no_back_to_back", 16'(int_pending), 16'd0);
        bus_write(16'hFF0F, 8'h00);

        // Highest vector
        bus_write(16'hFFFF, 8'h10);
        raise(5'h10);
        do_reti();
        dispatch("joypad", 3'd4);
        ack_it();
        check_read("joypad_if_after", 16'hFF0F, 8'hE0, 1'b1);

        // Reset in the middle of a dispatch
        bus_write(16'hFFFF, 8'h08);
        raise(5'h08);
        do_reti();
        dispatch("serial", 3'd3);
        reset = 1'b1; int_req = 5'h01; int_ack = 1'b1;
        bif.bus_addr = 16'hFFFF; bif.bus_wdata = 8'hAA; bif.bus_wr = 1'b1;
        tick();
        reset = 1'b0; int_req = 5'h00; int_ack = 1'b0; bif.bus_wr = 1'b0;
        check_val("rst_mid_pending", 16'(int_pending), 16'd0);
        check_val("rst_mid_ime", 16'(ime), 16'd0);
        check_val("rst_mid_vector", 16'(int_vector), 16'd0);
        check_val("rst_mid_wake", 16'(halt_wake), 16'd0);
        check_read("rst_mid_if", 16'hFF0F, 8'hE0, 1'b1);
        check_read("rst_mid_ie", 16'hFFFF, 8'h00, 1'b1);

        tick();
        check_val("sb_drained", 16'(sb_vec.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
